// File: rtl/reg_bank_seven_scan.sv
// Register bank with a time-multiplexed hex seven-segment scan; outputs are registered (1 cycle latency).
// No backpressure: loads are always accepted. Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module reg_bank_seven_scan #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 3,
  parameter int SCAN_DIV = 4,
  localparam int DIGITS  = DATA_W / 4,
  localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_data,
  input  logic [NUM_REGS-1:0] io_load,
  input  logic [SEL_W-1:0]  io_sel,
  output logic [6:0]        io_seven,
  output logic [DIGITS-1:0] io_digit
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]  digit_idx;

  logic [DATA_W-1:0] sel_dat;
  logic              sel_vld;
  logic [3:0]        nib_dat;
  logic              blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // No priority between strobes: every strobed register takes the same data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (io_load[i]) regs[i] <= io_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (digit_idx == IDX_W'(DIGITS - 1)) digit_idx <= '0;
      else                                 digit_idx <= digit_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Decoded select keeps an out-of-range index from ever touching the array.
  always_comb begin
    sel_dat = '0;
    sel_vld = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (io_sel == SEL_W'(i)) begin
        sel_dat = regs[i];
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    nib_dat = '0;
    blank   = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        nib_dat = sel_dat[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        blank   = (k > 0) && ((sel_dat >> (4*k)) == '0);
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_seven <= 7'h00;
      io_digit <= '0;
    end else begin
      io_digit <= DIGITS'(1) << digit_idx;
      io_seven <= (sel_vld && !blank) ? hex7(nib_dat) : 7'h00;
    end
  end

endmodule

// File: tb/tb_reg_bank_seven_scan.sv
// Directed bench for reg_bank_seven_scan at DATA_W=8, NUM_REGS=3, SCAN_DIV=4.
module tb_reg_bank_seven_scan;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] io_data;
  logic [2:0] io_load;
  logic [1:0] io_sel;
  logic [6:0] io_seven;
  logic [1:0] io_digit;

  int n_cmp = 0;
  int n_err = 0;

  reg_bank_seven_scan #(.DATA_W(8), .NUM_REGS(3), .SCAN_DIV(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_data  (io_data),
    .io_load  (io_load),
    .io_sel   (io_sel),
    .io_seven (io_seven),
    .io_digit (io_digit)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a given digit enable; an expired bound is a failed comparison.
  task automatic wait_digit(input string tag, input logic [1:0] target);
    int k;
    k = 0;
    while (io_digit !== target && k < 16) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_digit"}, {6'b0, io_digit}, {6'b0, target});
  endtask

  task automatic scan_pair(input string tag, input logic [6:0] exp0, input logic [6:0] exp1);
    wait_digit({tag, "_d0"}, 2'b01);
    chk({tag, "_seg0"}, {1'b0, io_seven}, {1'b0, exp0});
    wait_digit({tag, "_d1"}, 2'b10);
    chk({tag, "_seg1"}, {1'b0, io_seven}, {1'b0, exp1});
  endtask

  initial begin
    logic [1:0] exp_d;
    reset   = 1'b0;
    io_data = 8'h00;
    io_load = 3'b000;
    io_sel  = 2'd0;

    // reset held for two cycles
    tick(2);
    chk("rst_seven", {1'b0, io_seven}, 8'h00);
    chk("rst_digit", {6'b0, io_digit}, 8'h00);

    // release: 01 x4, 10 x4, then 01 again, all showing 0
    reset = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      exp_d = (c < 4) ? 2'b01 : (c < 8) ? 2'b10 : 2'b01;
      chk($sformatf("scan_digit_%0d", c), {6'b0, io_digit}, {6'b0, exp_d});
      chk($sformatf("scan_seven_%0d", c), {1'b0, io_seven}, 8'h3F);
    end

    // single load of A5 into register 0
    io_data = 8'hA5;
    io_load = 3'b001;
    tick(1);
    io_load = 3'b000;
    tick(1);
    scan_pair("load_a5", 7'h6D, 7'h77);

    // simultaneous load of 3F into registers 1 and 2
    io_data = 8'h3F;
    io_load = 3'b110;
    tick(1);
    io_load = 3'b000;
    io_sel  = 2'd1;
    tick(1);
    scan_pair("sel1_3f", 7'h71, 7'h4F);
    io_sel = 2'd2;
    tick(1);
    scan_pair("sel2_3f", 7'h71, 7'h4F);
    io_sel = 2'd0;
    tick(1);
    scan_pair("sel0_a5", 7'h6D, 7'h77);

    // out-of-range select blanks but keeps scanning
    io_sel = 2'd3;
    tick(1);
    scan_pair("sel3_blank", 7'h00, 7'h00);

    // async reset while digit 1 of A5 is shown
    io_sel = 2'd0;
    tick(1);
    wait_digit("pre_arst", 2'b10);
    chk("pre_arst_seven", {1'b0, io_seven}, 8'h77);
    #2 reset = 1'b0;
    #1;
    chk("arst_seven", {1'b0, io_seven}, 8'h00);
    chk("arst_digit", {6'b0, io_digit}, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    tick(1);
    scan_pair("post_arst_r0", 7'h3F, 7'h3F);
    io_sel = 2'd1;
    tick(1);
    scan_pair("post_arst_r1", 7'h3F, 7'h3F);

    // leading-zero handling
    io_sel  = 2'd0;
    io_data = 8'h05;
    io_load = 3'b001;
    tick(1);
    io_load = 3'b000;
    tick(1);
`ifdef LEADING_ZERO_BLANK_EN
    scan_pair("lz_05", 7'h6D, 7'h00);
`else
    scan_pair("lz_05", 7'h6D, 7'h3F);
`endif
    io_data = 8'h50;
    io_load = 3'b001;
    tick(1);
    io_load = 3'b000;
    tick(1);
    scan_pair("lz_50", 7'h3F, 7'h6D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
